countdown_timer: RTL

Loadable down-counter with prescaler and one-shot/auto-reload modes. It complements the up-counting `counter` leaf: it is loaded with a count, runs down to zero, and signals expiry. Wrappers use it to generate timeouts and periodic enables from the system clock, instantiated with `clk`/`reset` tied to `sys_clk`/`sys_reset`.

---
 rtl/countdown_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with a prescaler and one-shot/auto-reload modes.
// Expiry is flagged by a single-cycle registered pulse on the edge the count leaves 1.
module countdown_timer #(
   parameter int WIDTH          = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic                      stop,
   input  logic                      enable,
   input  logic                      auto_reload,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]          count,
   output logic                      busy,
   output logic                      expire
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                    state_r, state_s;
   logic [WIDTH-1:0]          count_r, count_s;
   logic [WIDTH-1:0]          reload_r, reload_s;
   logic [PRESCALE_WIDTH-1:0] presc_r, presc_s;
   logic                      expire_r, expire_s;
   logic                      busy_r;

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         count_r  <= {WIDTH{1'b0}};
         reload_r <= {WIDTH{1'b0}};
         presc_r  <= {PRESCALE_WIDTH{1'b0}};
         expire_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         reload_r <= reload_s;
         presc_r  <= presc_s;
         expire_r <= expire_s;
         busy_r   <= (state_s == RUN);
      end
   end

   // Next-state logic; priority is load, then stop, then the prescaled tick.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      reload_s = reload_r;
      presc_s  = presc_r;
      expire_s = 1'b0;
      if (load) begin
         count_s  = load_value;
         reload_s = load_value;
         presc_s  = {PRESCALE_WIDTH{1'b0}};
         if (load_value != {WIDTH{1'b0}}) begin
            state_s = RUN;
         end else begin
            state_s = IDLE;
         end
      end else if (stop) begin
         state_s = IDLE;
         presc_s = {PRESCALE_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            RUN: begin
               if (enable) begin
                  // >= so that a prescale lowered mid-run ticks on the next enabled cycle
                  if (presc_r >= prescale) begin
                     presc_s = {PRESCALE_WIDTH{1'b0}};
                     if (count_r > WIDTH'(1)) begin
                        count_s = count_r - WIDTH'(1);
                     end else begin
                        expire_s = 1'b1;
                        if (auto_reload) begin
                           count_s = reload_r;
                        end else begin
                           count_s = {WIDTH{1'b0}};
                           state_s = IDLE;
                        end
                     end
                  end else begin
                     presc_s = presc_r + PRESCALE_WIDTH'(1);
                  end
               end else begin
                  presc_s = presc_r;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   assign count  = count_r;
   assign busy   = busy_r;
   assign expire = expire_r;

endmodule
